lsu_mem_initiator: RTL



---
 rtl/lsu_mem_initiator_if.sv | 29 ++
 rtl/lsu_mem_initiator.sv | 97 +++++++++
 2 files changed

// File: rtl/lsu_mem_initiator_if.sv
// lsu_mem_initiator_if: pipeline request/response plus unified-memory data port.
// misalign_err is present only when LSU_MISALIGN_TRAP_EN is defined.
interface lsu_mem_initiator_if;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, busy, rw;
  logic [31:0] resp_rdata, am2, dm3, dm2;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_err;
  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm2,
    output req_ready, resp_valid, resp_rdata, busy, am2, rw, dm3, misalign_err
  );
  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm2,
    input  req_ready, resp_valid, resp_rdata, busy, am2, rw, dm3, misalign_err
  );
`else
  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm2,
    output req_ready, resp_valid, resp_rdata, busy, am2, rw, dm3
  );
  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm2,
    input  req_ready, resp_valid, resp_rdata, busy, am2, rw, dm3
  );
`endif
endinterface

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: sequences one load/store onto a strobe-less memory port (one am2 event per access).
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word requests skip memory and respond with misalign_err.
module lsu_mem_initiator #(
  parameter logic [31:0] PARK_XOR = 32'h0000_0004
) (
  input logic clk,
  input logic reset,
  lsu_mem_initiator_if.master bus
);
  typedef enum logic [2:0] {IDLE, PARK, ISSUE, SETUP, WR, RESP} state_e;
  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, rd_q, rd_d, am2_q, am2_d, dm3_q, dm3_d;
  logic [31:0] rdata_q, rdata_d, merge, ext;
  logic [1:0]  size_q;
  logic        we_q, sgn_q, mrg_q, mrg_d, rw_q, rv_q, busy_q, mis_q, accept, sub, mis;
  assign accept = bus.req_valid && state_q == IDLE;
  assign sub    = !size_q[1];
  assign addr_d = accept ? bus.req_addr : addr_q;
  assign rd_d   = state_q == ISSUE ? bus.dm2 : rd_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = accept && ((bus.req_size == 2'b01 && bus.req_addr[0]) ||
                          (bus.req_size[1] && bus.req_addr[1:0] != 2'b00));
  assign bus.misalign_err = mis_q;
`else
  assign mis = 1'b0;
`endif
  assign merge = size_q == 2'b00 ? {rd_q[31:8], wdata_q[7:0]} :
                 size_q == 2'b01 ? {rd_q[31:16], wdata_q[15:0]} : wdata_q;
  assign ext   = size_q == 2'b00 ? {{24{sgn_q & rd_d[7]}}, rd_d[7:0]} :
                 size_q == 2'b01 ? {{16{sgn_q & rd_d[15]}}, rd_d[15:0]} : rd_d;
  always_comb begin
    state_d = state_q;
    mrg_d   = mrg_q;
    unique case (state_q)
      IDLE:  begin
        state_d = accept ? (mis ? RESP : PARK) : IDLE;
        mrg_d   = accept ? 1'b0 : mrg_q;
      end
      PARK:  state_d = (!we_q || (sub && !mrg_q)) ? ISSUE : SETUP;
      ISSUE: begin
        state_d = we_q ? PARK : RESP;
        mrg_d   = we_q;
      end
      SETUP: state_d = WR;
      WR:    state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they are derived from the state being entered
    am2_d   = (state_d == PARK || state_d == SETUP) ? addr_d ^ PARK_XOR :
              (state_d == ISSUE || state_d == WR) ? addr_d : am2_q;
    dm3_d   = state_d == SETUP ? merge : dm3_q;
    rdata_d = state_d == RESP ? ((we_q || mis) ? 32'h0 : ext) : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      mrg_q   <= 1'b0;
      rd_q    <= '0;
      am2_q   <= '0;
      rw_q    <= 1'b0;
      dm3_q   <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= accept ? bus.req_wdata : wdata_q;
      size_q  <= accept ? bus.req_size : size_q;
      we_q    <= accept ? bus.req_we : we_q;
      sgn_q   <= accept ? bus.req_signed : sgn_q;
      mrg_q   <= mrg_d;
      rd_q    <= rd_d;
      am2_q   <= am2_d;
      rw_q    <= state_d == SETUP || state_d == WR;
      dm3_q   <= dm3_d;
      rv_q    <= state_d == RESP;
      rdata_q <= rdata_d;
      busy_q  <= state_d != IDLE;
      mis_q   <= mis;
    end
  end
  assign bus.req_ready  = state_q == IDLE;
  assign bus.am2        = am2_q;
  assign bus.rw         = rw_q;
  assign bus.dm3        = dm3_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.busy       = busy_q;
endmodule
